// File: rtl/stage_ex_pkg.sv
// Shared types for the execute stage: ALU opcodes, forward selects, mul/div
// state encoding and the EX/MA pipeline-register layout.
package stage_ex_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLL    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_SLT    = 4'd8,
    ALU_SLTU   = 4'd9,
    ALU_MUL    = 4'd10,
    ALU_DIVU   = 4'd11,
    ALU_REMU   = 4'd12,
    ALU_PASS_B = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF     = 2'b00,
    FWD_EXMA   = 2'b01,
    FWD_WB     = 2'b10,
    FWD_RF_ALT = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MD_MUL,
    MD_DIVU,
    MD_REMU
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_state_e;

  typedef struct packed {
    logic [2:0]        wb;
    logic [1:0]        ma;
    logic [DATA_W-1:0] alu_rslt;
    logic [DATA_W-1:0] rs2_val;
    logic [4:0]        rs2_addr;
    logic [DATA_W-1:0] pc;
    logic [4:0]        rdst;
  } exma_t;

  function automatic logic is_muldiv(input alu_op_e op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/stage_ex_muldiv_iter.sv
// Iterative multiply / unsigned divide: one shift-add or restoring-divide step
// per cycle for MD_CYCLES cycles, then holds the result in DONE.
module ex_muldiv_iter
  import stage_ex_pkg::*;
#(
  parameter int unsigned WIDTH     = DATA_W,
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  md_op_e           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(MD_CYCLES + 1);

  md_state_e        state_q, state_d;
  md_op_e           op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic [WIDTH:0]   rem_shift, rem_sub;
  logic             last_step;

  assign last_step = (cnt_q == CNT_W'(MD_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MD_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE: if (start) state_d = MD_BUSY;
        MD_BUSY: if (last_step) state_d = MD_DONE;
        MD_DONE: state_d = MD_DONE;
        default: state_d = MD_IDLE;
      endcase
    end
  end

  always_comb begin
    busy   = ((state_q == MD_IDLE) && start) || (state_q == MD_BUSY);
    done   = (state_q == MD_DONE);
    result = (op_q == MD_DIVU) ? lo_q : hi_q;
  end

  // hi: product accumulator or partial remainder; lo: multiplier or quotient
  assign rem_shift = {hi_q, lo_q[WIDTH-1]};
  assign rem_sub   = rem_shift - {1'b0, b_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= MD_MUL;
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
    end else if ((state_q == MD_IDLE) && start && !abort) begin
      op_q  <= op;
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= (op == MD_MUL) ? b : a;
      b_q   <= (op == MD_MUL) ? a : b;
    end else if (state_q == MD_BUSY) begin
      cnt_q <= cnt_q + 1'b1;
      if (op_q == MD_MUL) begin
        if (lo_q[0]) hi_q <= hi_q + b_q;
        lo_q <= lo_q >> 1;
        b_q  <= b_q << 1;
      end else if (!rem_sub[WIDTH]) begin
        hi_q <= rem_sub[WIDTH-1:0];
        lo_q <= {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_q <= rem_shift[WIDTH-1:0];
        lo_q <= {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/stage_ex.sv
// Execute stage: operand forwarding, ALU, optional iterative mul/div and the
// EX/MA pipeline register. Define STAGE_EX_MULDIV_EN to build the mul/div unit.
module stage_ex
  import stage_ex_pkg::*;
#(
  parameter int unsigned WIDTH     = DATA_W,
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       i_ex_WB,
  input  logic [1:0]       i_ex_MA,
  input  logic [3:0]       i_ex_ALUop,
  input  logic             i_ex_use_imm,
  input  logic [WIDTH-1:0] i_ex_imm,
  input  logic [WIDTH-1:0] i_ex_Rs1_val,
  input  logic [WIDTH-1:0] i_ex_Rs2_val,
  input  logic [4:0]       i_ex_Rs2_addr,
  input  logic [WIDTH-1:0] i_ex_PC,
  input  logic [4:0]       i_ex_Rdst,
  input  logic [1:0]       i_fwd_A,
  input  logic [1:0]       i_fwd_B,
  input  logic [WIDTH-1:0] i_ex_mux_wb,
  input  logic             i_ex_flush,
  input  logic             i_ex_stall,
  output logic [2:0]       o_ex_WB,
  output logic [1:0]       o_ex_MA,
  output logic [WIDTH-1:0] o_ex_ALU_rslt,
  output logic [WIDTH-1:0] o_ex_Rs2_val,
  output logic [4:0]       o_ex_Rs2_addr,
  output logic [WIDTH-1:0] o_ex_PC,
  output logic [4:0]       o_ex_Rdst,
  output logic             o_ex_busy
);

  alu_op_e          alu_op;
  logic [WIDTH-1:0] opnd_a, rs2_fwd, opnd_b, alu_rslt, ex_rslt;
  logic             md_busy;
  exma_t            exma_q, exma_d;

  assign alu_op = alu_op_e'(i_ex_ALUop);

  always_comb begin
    case (fwd_sel_e'(i_fwd_A))
      FWD_EXMA: opnd_a = exma_q.alu_rslt;
      FWD_WB:   opnd_a = i_ex_mux_wb;
      default:  opnd_a = i_ex_Rs1_val;
    endcase
    case (fwd_sel_e'(i_fwd_B))
      FWD_EXMA: rs2_fwd = exma_q.alu_rslt;
      FWD_WB:   rs2_fwd = i_ex_mux_wb;
      default:  rs2_fwd = i_ex_Rs2_val;
    endcase
    opnd_b = i_ex_use_imm ? i_ex_imm : rs2_fwd;
  end

  always_comb begin
    case (alu_op)
      ALU_ADD:  alu_rslt = opnd_a + opnd_b;
      ALU_SUB:  alu_rslt = opnd_a - opnd_b;
      ALU_AND:  alu_rslt = opnd_a & opnd_b;
      ALU_OR:   alu_rslt = opnd_a | opnd_b;
      ALU_XOR:  alu_rslt = opnd_a ^ opnd_b;
      ALU_SLL:  alu_rslt = opnd_a << opnd_b[4:0];
      ALU_SRL:  alu_rslt = opnd_a >> opnd_b[4:0];
      ALU_SRA:  alu_rslt = $signed(opnd_a) >>> opnd_b[4:0];
      ALU_SLT:  alu_rslt = {{(WIDTH-1){1'b0}}, ($signed(opnd_a) < $signed(opnd_b))};
      ALU_SLTU: alu_rslt = {{(WIDTH-1){1'b0}}, (opnd_a < opnd_b)};
      ALU_MUL, ALU_DIVU, ALU_REMU: alu_rslt = '0;
      default:  alu_rslt = opnd_b;
    endcase
  end

`ifdef STAGE_EX_MULDIV_EN
  logic             md_start, md_abort, md_done;
  logic [WIDTH-1:0] md_rslt;
  md_op_e           md_op;

  assign md_start = is_muldiv(alu_op) & ~i_ex_flush & ~i_ex_stall & ~rst;
  // Leaving DONE reuses abort: EX/MA captures the result on that same edge.
  assign md_abort = i_ex_flush | (md_done & ~i_ex_stall);

  always_comb begin
    case (alu_op)
      ALU_MUL:  md_op = MD_MUL;
      ALU_DIVU: md_op = MD_DIVU;
      default:  md_op = MD_REMU;
    endcase
  end

  ex_muldiv_iter #(
    .WIDTH    (WIDTH),
    .MD_CYCLES(MD_CYCLES)
  ) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .op    (md_op),
    .a     (opnd_a),
    .b     (opnd_b),
    .abort (md_abort),
    .busy  (md_busy),
    .done  (md_done),
    .result(md_rslt)
  );

  assign ex_rslt = is_muldiv(alu_op) ? md_rslt : alu_rslt;
`else
  logic unused_md_cfg;
  assign unused_md_cfg = ^MD_CYCLES;
  assign md_busy       = 1'b0;
  assign ex_rslt       = alu_rslt;
`endif

  assign exma_d = '{wb: i_ex_WB, ma: i_ex_MA, alu_rslt: ex_rslt, rs2_val: rs2_fwd,
                    rs2_addr: i_ex_Rs2_addr, pc: i_ex_PC, rdst: i_ex_Rdst};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              exma_q <= '0;
    else if (i_ex_flush)  exma_q <= '0;
    else if (!i_ex_stall) exma_q <= md_busy ? '0 : exma_d;
  end

  assign o_ex_WB       = exma_q.wb;
  assign o_ex_MA       = exma_q.ma;
  assign o_ex_ALU_rslt = exma_q.alu_rslt;
  assign o_ex_Rs2_val  = exma_q.rs2_val;
  assign o_ex_Rs2_addr = exma_q.rs2_addr;
  assign o_ex_PC       = exma_q.pc;
  assign o_ex_Rdst     = exma_q.rdst;
  assign o_ex_busy     = md_busy;

endmodule

// File: tb/tb_stage_ex.sv
// Self-checking bench for stage_ex: randomized single-cycle ops against a
// behavioural model, then directed forwarding, reset and mul/div scenarios.
module tb_stage_ex;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  wb;
  logic [1:0]  ma;
  logic [3:0]  op;
  logic        use_imm;
  logic [31:0] imm, rs1, rs2, pc, mux_wb;
  logic [4:0]  rs2_addr, rdst;
  logic [1:0]  fwd_a, fwd_b;
  logic        flush, stall;

  logic [2:0]  o_wb;
  logic [1:0]  o_ma;
  logic [31:0] o_rslt, o_rs2v, o_pc;
  logic [4:0]  o_rs2a, o_rdst;
  logic        o_busy;

  stage_ex dut (
    .clk(clk), .rst(rst),
    .i_ex_WB(wb), .i_ex_MA(ma), .i_ex_ALUop(op), .i_ex_use_imm(use_imm),
    .i_ex_imm(imm), .i_ex_Rs1_val(rs1), .i_ex_Rs2_val(rs2),
    .i_ex_Rs2_addr(rs2_addr), .i_ex_PC(pc), .i_ex_Rdst(rdst),
    .i_fwd_A(fwd_a), .i_fwd_B(fwd_b), .i_ex_mux_wb(mux_wb),
    .i_ex_flush(flush), .i_ex_stall(stall),
    .o_ex_WB(o_wb), .o_ex_MA(o_ma), .o_ex_ALU_rslt(o_rslt),
    .o_ex_Rs2_val(o_rs2v), .o_ex_Rs2_addr(o_rs2a), .o_ex_PC(o_pc),
    .o_ex_Rdst(o_rdst), .o_ex_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference EX/MA contents
  logic [2:0]  e_wb;
  logic [1:0]  e_ma;
  logic [31:0] e_rslt, e_rs2v, e_pc;
  logic [4:0]  e_rs2a, e_rdst;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (f)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return $signed(a) >>> sh;
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
`ifdef STAGE_EX_MULDIV_EN
      4'd10: return a * b;
      4'd11: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      4'd12: return (b == 32'd0) ? a : a % b;
`else
      4'd10, 4'd11, 4'd12: return 32'd0;
`endif
      default: return b;
    endcase
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_wb"},   {29'd0, o_wb},   {29'd0, e_wb});
    check({tag, "_ma"},   {30'd0, o_ma},   {30'd0, e_ma});
    check({tag, "_rslt"}, o_rslt,          e_rslt);
    check({tag, "_rs2v"}, o_rs2v,          e_rs2v);
    check({tag, "_rs2a"}, {27'd0, o_rs2a}, {27'd0, e_rs2a});
    check({tag, "_pc"},   o_pc,            e_pc);
    check({tag, "_rdst"}, {27'd0, o_rdst}, {27'd0, e_rdst});
  endtask

  task automatic drive_idle();
    wb = 3'd0; ma = 2'd0; op = 4'd0; use_imm = 1'b0; imm = '0; rs1 = '0; rs2 = '0;
    rs2_addr = '0; pc = '0; rdst = '0; fwd_a = 2'd0; fwd_b = 2'd0; mux_wb = '0;
    flush = 1'b0; stall = 1'b0;
  endtask

`ifdef STAGE_EX_MULDIV_EN
  task automatic run_md(input string tag, input logic [3:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int nstall);
    int          bc;
    logic        bub_ok;
    logic [31:0] pc_v;
    pc_v = $urandom;
    op = f; rs1 = a; rs2 = b; use_imm = 1'b0; fwd_a = 2'd0; fwd_b = 2'd0;
    wb = 3'b011; ma = 2'b01; pc = pc_v; rdst = 5'd3; flush = 1'b0; stall = 1'b0;
    #1;
    bc = 0;
    bub_ok = 1'b1;
    while (o_busy && bc < 40) begin
      bc++;
      step();
      if (o_wb !== 3'd0 || o_rslt !== 32'd0) bub_ok = 1'b0;
    end
    check({tag, "_busy_cycles"}, bc, 33);
    check({tag, "_bubble"}, {31'd0, bub_ok}, 32'd1);
    if (nstall > 0) begin
      stall = 1'b1;
      repeat (nstall) step();
      check({tag, "_stall_rslt"}, o_rslt, 32'd0);
      check({tag, "_stall_busy"}, {31'd0, o_busy}, 32'd0);
      stall = 1'b0;
    end
    step();
    check({tag, "_rslt"}, o_rslt, exp);
    check({tag, "_wb"}, {29'd0, o_wb}, 32'd3);
    check({tag, "_pc"}, o_pc, pc_v);
  endtask
`endif

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a_ref, rs2_ref, b_ref, r;

    drive_idle();
    rst = 1'b1;
    #12;
    check("rst_wb",   {29'd0, o_wb}, 32'd0);
    check("rst_ma",   {30'd0, o_ma}, 32'd0);
    check("rst_rslt", o_rslt, 32'd0);
    check("rst_rs2v", o_rs2v, 32'd0);
    check("rst_pc",   o_pc, 32'd0);
    check("rst_rdst", {27'd0, o_rdst}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    rst = 1'b0;
    step();
    e_wb = '0; e_ma = '0; e_rslt = '0; e_rs2v = '0; e_rs2a = '0; e_pc = '0; e_rdst = '0;

    for (int i = 0; i < 40; i++) begin
      wb = 3'($urandom); ma = 2'($urandom); op = 4'($urandom);
`ifdef STAGE_EX_MULDIV_EN
      if (op >= 4'd10 && op <= 4'd12) op = 4'd13;
`endif
      use_imm = 1'($urandom); imm = $urandom; rs1 = $urandom; rs2 = $urandom;
      if (i % 4 == 0) rs2 = {27'd0, 5'($urandom)};
      rs2_addr = 5'($urandom); pc = $urandom; rdst = 5'($urandom);
      fwd_a = 2'($urandom); fwd_b = 2'($urandom); mux_wb = $urandom;
      flush = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 7) == 0);
      a_ref   = (fwd_a == 2'd1) ? e_rslt : (fwd_a == 2'd2) ? mux_wb : rs1;
      rs2_ref = (fwd_b == 2'd1) ? e_rslt : (fwd_b == 2'd2) ? mux_wb : rs2;
      b_ref   = use_imm ? imm : rs2_ref;
      r = ref_alu(op, a_ref, b_ref);
      step();
      if (flush) begin
        e_wb = '0; e_ma = '0; e_rslt = '0; e_rs2v = '0; e_rs2a = '0; e_pc = '0; e_rdst = '0;
      end else if (!stall) begin
        e_wb = wb; e_ma = ma; e_rslt = r; e_rs2v = rs2_ref; e_rs2a = rs2_addr;
        e_pc = pc; e_rdst = rdst;
      end
      check_model("rand");
      check("rand_busy", {31'd0, o_busy}, 32'd0);
    end

    drive_idle();
    rs1 = 32'd5; imm = 32'hFFFF_FFFD; use_imm = 1'b1; op = 4'd0;
    wb = 3'b101; ma = 2'b10; pc = 32'h100; rdst = 5'd7; rs2 = 32'h55; rs2_addr = 5'd9;
    step();
    check("add_rslt", o_rslt, 32'd2);
    check("add_wb",   {29'd0, o_wb}, 32'd5);
    check("add_ma",   {30'd0, o_ma}, 32'd2);
    check("add_pc",   o_pc, 32'h100);
    check("add_rdst", {27'd0, o_rdst}, 32'd7);
    check("add_rs2v", o_rs2v, 32'h55);
    check("add_rs2a", {27'd0, o_rs2a}, 32'd9);

    rs1 = 32'h10; imm = 32'd0;
    step();
    check("fwd_prior", o_rslt, 32'h10);
    fwd_a = 2'b01; fwd_b = 2'b10; mux_wb = 32'h3; rs1 = 32'hDEAD; rs2 = 32'hBEEF;
    use_imm = 1'b0; op = 4'd1;
    step();
    check("fwd_sub", o_rslt, 32'hD);
    check("fwd_store", o_rs2v, 32'h3);

    fwd_a = 2'b11; fwd_b = 2'b11; rs1 = 32'd20; rs2 = 32'd8;
    step();
    check("fwd11_sub", o_rslt, 32'd12);
    check("fwd11_store", o_rs2v, 32'd8);

    #2 rst = 1'b1;
    #1;
    check("arst_rslt", o_rslt, 32'd0);
    check("arst_pc",   o_pc, 32'd0);
    check("arst_wb",   {29'd0, o_wb}, 32'd0);
    check("arst_rdst", {27'd0, o_rdst}, 32'd0);
    #1 rst = 1'b0;
    drive_idle();
    step();

`ifdef STAGE_EX_MULDIV_EN
    run_md("mul_big", 4'd10, 32'h10000, 32'h10000, 32'h0, 0);
    run_md("mul_7x6", 4'd10, 32'd7, 32'd6, 32'd42, 0);
    run_md("divu",    4'd11, 32'd100, 32'd7, 32'd14, 3);
    run_md("remu",    4'd12, 32'd100, 32'd7, 32'd2, 0);
    run_md("divu_z",  4'd11, 32'd9, 32'd0, 32'hFFFF_FFFF, 0);
    run_md("remu_z",  4'd12, 32'd9, 32'd0, 32'd9, 0);
    for (int k = 0; k < 4; k++) begin
      logic [3:0]  f;
      logic [31:0] ra, rb;
      f  = 4'(10 + $urandom_range(0, 2));
      ra = $urandom;
      rb = (k == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      run_md("md_rand", f, ra, rb, ref_alu(f, ra, rb), 0);
    end

    op = 4'd10; rs1 = 32'd3; rs2 = 32'd5;
    #1;
    repeat (11) step();
    flush = 1'b1;
    #1;
    check("flush_busy_during", {31'd0, o_busy}, 32'd1);
    step();
    check("flush_busy_after", {31'd0, o_busy}, 32'd0);
    check("flush_wb", {29'd0, o_wb}, 32'd0);
    check("flush_rslt", o_rslt, 32'd0);
    flush = 1'b0; op = 4'd0; rs1 = 32'd1; rs2 = 32'd2;
    #1;
    check("flush_idle_busy", {31'd0, o_busy}, 32'd0);
    step();
    check("flush_next_add", o_rslt, 32'd3);
    run_md("mul_after_flush", 4'd10, 32'd3, 32'd5, 32'd15, 0);

    op = 4'd10; rs1 = 32'd3; rs2 = 32'd5;
    #1;
    repeat (6) step();
    check("arst_md_busy_pre", {31'd0, o_busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_md_busy", {31'd0, o_busy}, 32'd0);
    check("arst_md_wb", {29'd0, o_wb}, 32'd0);
    check("arst_md_rslt", o_rslt, 32'd0);
    check("arst_md_pc", o_pc, 32'd0);
    drive_idle();
    #1 rst = 1'b0;
    step();
    run_md("mul_after_rst", 4'd10, 32'd11, 32'd13, 32'd143, 0);
    drive_idle();
    step();
`else
    op = 4'd10; rs1 = 32'd7; rs2 = 32'd6; wb = 3'b110; pc = 32'h44;
    #1;
    check("nomd_mul_busy", {31'd0, o_busy}, 32'd0);
    step();
    check("nomd_mul_rslt", o_rslt, 32'd0);
    check("nomd_mul_wb", {29'd0, o_wb}, 32'd6);
    check("nomd_mul_pc", o_pc, 32'h44);
    op = 4'd11; rs1 = 32'd9; rs2 = 32'd0;
    step();
    check("nomd_divu_rslt", o_rslt, 32'd0);
    op = 4'd12; rs1 = 32'd100; rs2 = 32'd7;
    step();
    check("nomd_remu_rslt", o_rslt, 32'd0);
    check("nomd_remu_busy", {31'd0, o_busy}, 32'd0);
    op = 4'd0; rs1 = 32'd4; rs2 = 32'd5;
    step();
    check("nomd_add_after", o_rslt, 32'd9);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stage_ex.md
Name: stage_ex

Overview:
Execute stage of the 5-stage pipeline, directly upstream of the memory-access stage. It resolves operand forwarding, selects the immediate, and computes single-cycle ALU results. An iterative 32-cycle multiply/divide unit stalls the front end while it runs. Results and control are registered into the EX/MA pipeline register that feeds the memory-access stage.

Parameters:
WIDTH, 32, datapath width (fixed 32; `WIDTH from pipelinedefs)
MD_CYCLES, 32, iteration count of the mul/div unit

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
i_ex_WB  in  3  write-back control, passed through
i_ex_MA  in  2  memory-access control, passed through
i_ex_ALUop  in  4  ALU operation code
i_ex_use_imm  in  1  1: operand B = immediate
i_ex_imm  in  32  sign-extended immediate
i_ex_Rs1_val  in  32  register-file value of rs1
i_ex_Rs2_val  in  32  register-file value of rs2
i_ex_Rs2_addr  in  5  rs2 address, passed through for store forwarding
i_ex_PC  in  32  program counter
i_ex_Rdst  in  5  destination register
i_fwd_A  in  2  forward select for operand A
i_fwd_B  in  2  forward select for operand B / store data
i_ex_mux_wb  in  32  MA/WB write-back value (forward source)
i_ex_flush  in  1  kill the instruction in EX
i_ex_stall  in  1  downstream stall (e.g. D-cache miss)
o_ex_WB  out  3  registered WB control
o_ex_MA  out  2  registered MA control
o_ex_ALU_rslt  out  32  registered result
o_ex_Rs2_val  out  32  registered forwarded rs2 (store data)
o_ex_Rs2_addr  out  5  registered rs2 address
o_ex_PC  out  32  registered PC
o_ex_Rdst  out  5  registered destination
o_ex_busy  out  1  mul/div in progress; upstream must hold

Behaviour:
- Reset: every registered output is 0, FSM is IDLE, counter is 0, and o_ex_busy is 0.
- Reset is asynchronous and active-high. Asserting it mid-operation aborts the mul/div.
- Forwarding:
  - sel 00 selects the register-file value.
  - sel 01 selects o_ex_ALU_rslt (EX/MA).
  - sel 10 selects i_ex_mux_wb.
  - sel 11 is treated as 00.
  - Operand B = i_ex_use_imm ? i_ex_imm : forwarded rs2.
  - Store data is always the forwarded rs2.
- ALUop encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA, each using B[4:0].
  - 8 SLT, 9 SLTU, each giving a 0/1 result.
  - 10 MUL (low 32 bits of the product).
  - 11 DIVU, 12 REMU.
  - 13-15 pass B.
  - All arithmetic is mod 2^32.
- Single-cycle ops: the result is captured into EX/MA on the next edge.
- Mul/div FSM:
  - IDLE → BUSY when a mul/div op is present and neither flush nor stall is asserted. Operands latch, counter = 0.
  - BUSY: one shift-add (MUL) or restoring-divide step per cycle. After MD_CYCLES steps → DONE.
  - DONE: the result drives the EX/MA input. On the first edge with i_ex_stall = 0, EX/MA captures it and the FSM → IDLE. The FSM stays in DONE while stalled.
  - o_ex_busy = 1 combinationally from the cycle the op is presented in IDLE through the last BUSY cycle, i.e. exactly 33 cycles. It is 0 in DONE.
  - While BUSY, EX/MA loads a bubble (WB = 0, MA = 0, other fields 0).
  - Divide by zero: DIVU = 0xFFFFFFFF, REMU = dividend. No exception is raised.
- EX/MA register priority: flush > stall > busy-bubble > load.
  - Flush loads a bubble.
  - Flush during BUSY or DONE also aborts the FSM to IDLE; the result is discarded.
  - Stall holds all contents.
- Back-to-back mul/div: the second op starts only from IDLE, i.e. the cycle after DONE is consumed.

Optional Feature:
STAGE_EX_MULDIV_EN
- Defined: iterative unit instantiated, behaviour as above.
- Undefined: ops 10-12 complete in one cycle with result 0, o_ex_busy is tied 0, and no FSM is present.

Decomposition:
- pipelinedefs.v holds:
  - ALU opcode `defines (ALU_ADD…ALU_REMU).
  - Forward-select codes.
  - `EXMA_WIDTH and field ranges `EXMA_RDST, `EXMA_PC, `EXMA_RS2VAL, `EXMA_RS2ADDR, `EXMA_ALURSLT, `EXMA_MA, `EXMA_WB.
- The existing pipereg is reused for EX/MA.
- One sub-module, ex_muldiv_iter, contains the FSM, counter and datapath, with ports start/op/a/b/abort → busy/done/result.

Test Plan:
- ADD with Rs1 = 5, imm = 0xFFFFFFFD, use_imm = 1 → o_ex_ALU_rslt = 2 one edge later; WB/MA/PC/Rdst passed through.
- Forward: fwd_A = 01 with prior result 0x10, fwd_B = 10 with mux_wb = 0x3, op SUB → 0xD.
- MUL 0x10000 × 0x10000 → busy high exactly 33 cycles, bubbles in EX/MA meanwhile, result 0x00000000. Then MUL 7 × 6 → 42.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 9/0 → 0xFFFFFFFF; REMU 9/0 → 9.
- Stall asserted in DONE for 3 cycles → result held and not captured; captured on the first edge after stall drops; FSM then IDLE.
- Flush at BUSY cycle 10 → busy drops next cycle, EX/MA holds a bubble (WB = 0), FSM IDLE. Async rst mid-BUSY → all outputs 0 immediately.
